// File: rtl/vga_mode_sched_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// vga_mode_sched_if : request/frame inputs and mode/blank outputs of the
//                     VGA display-mode scheduler.
// Rev 1.0
// ---------------------------------------------------------------------------
interface vga_mode_sched_if;
  logic [4:0] mode_req;
  logic       frame_start;
  logic [4:0] game_mode;
  logic       blank;
  logic       busy;
  logic       switch_done;

  modport master (
    output mode_req, frame_start,
    input  game_mode, blank, busy, switch_done
  );

  modport slave (
    input  mode_req, frame_start,
    output game_mode, blank, busy, switch_done
  );
endinterface
`default_nettype wire

// File: rtl/vga_mode_sched.sv
`default_nettype none
// ---------------------------------------------------------------------------
// vga_mode_sched : synchronizes mode requests and applies the chosen mode at a
//                  frame boundary with optional blanking. Optional idle
//                  auto-cycling is enabled by defining MODE_AUTOCYCLE_EN.
// Rev 1.0
// ---------------------------------------------------------------------------
module vga_mode_sched #(
  parameter int BLANK_FRAMES = 2,
  parameter int IDLE_FRAMES  = 600
) (
  input  wire logic       clk,
  input  wire logic       rst,
  vga_mode_sched_if.slave bus
);

  typedef enum logic [1:0] {
    SHOW  = 2'd0,
    ARMED = 2'd1,
    BLANK = 2'd2
  } state_t;

  localparam logic [3:0] LAST_BLANK = (BLANK_FRAMES > 0) ? 4'(BLANK_FRAMES - 1) : 4'd0;

  logic [4:0] meta_q, sync_q, sync_prev_q, rise_q, rise_d;
  state_t     state_q, state_d;
  logic [4:0] game_mode_q, game_mode_d;
  logic [4:0] pend_q, pend_d;
  logic       pend_vld_q, pend_vld_d;
  logic       blank_q, blank_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic [3:0] fcnt_q, fcnt_d;

  logic [4:0] ext_pick;
  logic       ext_accept;
  logic [4:0] auto_req;
  logic       accept;
  logic [4:0] req_pick;

  always_comb begin
    rise_d = sync_q & ~sync_prev_q;
  end

  // Lowest set bit wins; the rest are dropped.
  assign ext_pick   = rise_q & (~rise_q + 5'd1);
  assign ext_accept = (ext_pick != 5'd0) &&
                      ((state_q != SHOW) || (ext_pick != game_mode_q));

`ifdef MODE_AUTOCYCLE_EN
  logic [15:0] idle_q, idle_d;
  logic        auto_fire;

  always_comb begin
    auto_fire = 1'b0;
    idle_d    = idle_q;
    if ((state_q != SHOW) || ext_accept) begin
      idle_d = 16'd0;
    end else if (bus.frame_start) begin
      if (idle_q == 16'(IDLE_FRAMES - 1)) begin
        auto_fire = 1'b1;
        idle_d    = 16'd0;
      end else begin
        idle_d = idle_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) idle_q <= 16'd0;
    else      idle_q <= idle_d;
  end

  assign auto_req = auto_fire ? {game_mode_q[3:0], game_mode_q[4]} : 5'd0;
`else
  localparam int unused_idle_frames = IDLE_FRAMES;
  assign auto_req = 5'd0;
`endif

  assign accept   = ext_accept || (auto_req != 5'd0);
  assign req_pick = ext_accept ? ext_pick : auto_req;

  always_comb begin
    state_d     = state_q;
    game_mode_d = game_mode_q;
    pend_d      = pend_q;
    pend_vld_d  = pend_vld_q;
    blank_d     = blank_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    fcnt_d      = fcnt_q;

    if (accept) begin
      pend_d     = req_pick;
      pend_vld_d = 1'b1;
    end

    case (state_q)
      SHOW: begin
        if (accept) begin
          state_d = ARMED;
          busy_d  = 1'b1;
        end
      end
      ARMED: begin
        if (bus.frame_start) begin
          game_mode_d = pend_d;
          pend_vld_d  = 1'b0;
          if (BLANK_FRAMES == 0) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = SHOW;
          end else begin
            blank_d = 1'b1;
            fcnt_d  = 4'd0;
            state_d = BLANK;
          end
        end
      end
      BLANK: begin
        if (bus.frame_start) begin
          if (fcnt_q == LAST_BLANK) begin
            blank_d = 1'b0;
            done_d  = 1'b1;
            // A request taken during blanking re-arms only if it changes the mode.
            if (pend_vld_d && (pend_d != game_mode_q)) begin
              state_d = ARMED;
            end else begin
              state_d    = SHOW;
              busy_d     = 1'b0;
              pend_vld_d = 1'b0;
            end
          end else begin
            fcnt_d = fcnt_q + 4'd1;
          end
        end
      end
      default: begin
        state_d    = SHOW;
        busy_d     = 1'b0;
        blank_d    = 1'b0;
        pend_vld_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_q      <= 5'd0;
      sync_q      <= 5'd0;
      sync_prev_q <= 5'd0;
      rise_q      <= 5'd0;
      state_q     <= SHOW;
      game_mode_q <= 5'b00001;
      pend_q      <= 5'b00001;
      pend_vld_q  <= 1'b0;
      blank_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      fcnt_q      <= 4'd0;
    end else begin
      meta_q      <= bus.mode_req;
      sync_q      <= meta_q;
      sync_prev_q <= sync_q;
      rise_q      <= rise_d;
      state_q     <= state_d;
      game_mode_q <= game_mode_d;
      pend_q      <= pend_d;
      pend_vld_q  <= pend_vld_d;
      blank_q     <= blank_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      fcnt_q      <= fcnt_d;
    end
  end

  assign bus.game_mode   = game_mode_q;
  assign bus.blank       = blank_q;
  assign bus.busy        = busy_q;
  assign bus.switch_done = done_q;

endmodule
`default_nettype wire

// File: doc/vga_mode_sched.md
# vga_mode_sched

Display-mode scheduler for the VGA output path. It takes raw, asynchronous mode-request lines from the board, synchronizes and edge-detects them, and arbitrates simultaneous requests. It applies the chosen mode only at a frame boundary, blanking the picture for a set number of frames around each change. Its one-hot `game_mode` output drives the display-mode select of the VGA top level, so mode changes never tear mid-frame.

## Interface
- `BLANK_FRAMES`, default 2: frames of forced black after a mode change; 0 to 15 allowed, 0 means no blanking.
- `IDLE_FRAMES`, default 600: idle frames before an auto-cycle step; used only with `MODE_AUTOCYCLE_EN`; 1 to 65535.
- `clk`  in  1  system clock; the same clock that clocks the VGA timing logic.
- `rst`  in  1  asynchronous reset, active-low.
- `mode_req`  in  5  raw request levels, asynchronous to `clk`; bit i requests mode i.
- `frame_start`  in  1  single-cycle pulse in the `clk` domain at the first cycle of vertical blanking.
- `game_mode`  out  5  registered, always one-hot; reset value 5'b00001.
- `blank`  out  1  registered; forces black output while high; reset value 0.
- `busy`  out  1  registered; high while a switch is pending or blanking is in progress; reset value 0.
- `switch_done`  out  1  registered single-cycle pulse when a switch completes; reset value 0.

## Operation
**Request path**
- Each `mode_req` bit passes through a 2-FF synchronizer, then a rising-edge detector (sync2 & ~sync2_d).
- Multiple simultaneous rising edges: the lowest index wins. The others are dropped, not queued.
- A request for the currently displayed mode while in SHOW is ignored: no state change, no pulse.

**State machine** (reset state: SHOW)
- SHOW: `busy`=0, `blank`=0. On an accepted request: latch `pend_mode`, then go to ARMED.
- ARMED: `busy`=1. A new accepted request overwrites `pend_mode` (last request wins).
  - On `frame_start`: `game_mode` <= `pend_mode`.
  - If `BLANK_FRAMES`=0: pulse `switch_done` and go to SHOW.
  - Otherwise: `blank` <= 1, frame counter <= 0, go to BLANK.
- BLANK: `busy`=1, `blank`=1.
  - Each `frame_start` increments the 4-bit frame counter.
  - On the `frame_start` where the counter reaches `BLANK_FRAMES`-1: `blank` <= 0 and pulse `switch_done`.
  - Next state: if a request accepted during BLANK is held in `pend_mode` (valid flag set) and differs from the new `game_mode`, go to ARMED; otherwise go to SHOW.

**General rules**
- `game_mode` changes only on a `frame_start` cycle while in ARMED.
- `pend_mode` is stored one-hot. Its valid flag is cleared on entry to SHOW and whenever `pend_mode` is loaded into `game_mode`.

## Timing
- Request latency: a `mode_req` bit that rises and is set up before edge k makes `busy` go high after edge k+3 (2 synchronizer stages, edge-detect register, state register).
- Request minimum pulse width: 2 `clk` periods high and 2 `clk` periods low between requests on the same bit.
- Request acceptance coinciding with `frame_start` in SHOW: the state moves to ARMED and that `frame_start` is not consumed. The switch happens at the next `frame_start`.
- `game_mode` and `blank` update on the same edge. `switch_done` is high for exactly one cycle.
- Reset asserted mid-operation: all outputs and state return to their reset values asynchronously, and any pending request is discarded. The synchronizers also clear, so a level still held high after reset deassertion is seen as a new rising edge.

## Configuration
- `MODE_AUTOCYCLE_EN` defined:
  - A 16-bit frame counter counts `frame_start` pulses while in SHOW.
  - When it reaches `IDLE_FRAMES`, it generates an internal request for the next mode (rotate left, so mode 4 goes to mode 0) and follows the normal ARMED path.
  - The counter clears on any externally accepted request and on leaving SHOW.
- Not defined: no counter is built, and modes change only on external requests. Ports are identical in both builds.

## Test plan
- Reset: hold `rst`=0 -> `game_mode`=5'b00001 and `blank`=`busy`=`switch_done`=0. Release, run 10 frames with no requests -> outputs unchanged.
- Basic switch, `BLANK_FRAMES`=2: pulse `mode_req`[3] -> `busy`=1 after 3 cycles. At the next `frame_start`: `game_mode`=5'b01000, `blank`=1. At the 2nd following `frame_start`: `blank`=0 and one `switch_done` pulse.
- Simultaneous requests: raise bits 4 and 2 in the same cycle -> `game_mode` becomes 5'b00100. A request for the current mode -> `busy` stays 0.
- Retarget: request mode 1, then request mode 4 before `frame_start` -> the switch goes directly to 5'b10000. A request for mode 2 during BLANK -> ARMED is re-entered after blanking ends, finishing at 5'b00100.
- `BLANK_FRAMES`=0 plus mid-operation reset: the switch occurs with `blank` never asserted. Asserting `rst` while in BLANK -> immediate return to 5'b00001 with `blank`=0.
- `MODE_AUTOCYCLE_EN` with `IDLE_FRAMES`=3: idle for 3 frames -> an internal switch from mode 0 to mode 1. An external request at frame 2 -> the counter restarts.
